// File: rtl/matrix_loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : matrix_loader_pkg                                          |
// | Description : Shared types and constants for the matrix loader: FSM      |
// |               state encoding, error codes, header geometry.              |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package matrix_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR_M = 3'd1,
        ST_HDR_N = 3'd2,
        ST_HDR_P = 3'd3,
        ST_CHECK = 3'd4,
        ST_DATA  = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_DIM  = 2'b01;  // zero, odd or oversized dimension field
    localparam logic [1:0] ERR_CAP  = 2'b10;  // image does not fit in the RAM

    localparam int HDR_WORDS = 3;

    // RAM addresses of the dimension header words
    localparam int ADDR_M = 0;
    localparam int ADDR_N = 1;
    localparam int ADDR_P = 2;

endpackage
`default_nettype wire

// File: rtl/matrix_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : matrix_loader_if                                           |
// | Description : Word stream (valid/ready) plus RAM write port of the        |
// |               matrix loader.                                             |
// | Ports       : s_valid/s_ready/s_data  - incoming word stream             |
// |               ram_we/ram_addr/ram_wdata - RAM write port                 |
// |               slave modport  : loader side                               |
// |               master modport : stream source / RAM observer side         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface matrix_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output ram_we,
        output ram_addr,
        output ram_wdata
    );

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  ram_we,
        input  ram_addr,
        input  ram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/matrix_dim_check.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : matrix_dim_check                                           |
// | Description : Combinational validation of the m/n/p header. Flags bad    |
// |               dimension fields first, then RAM overflow, and reports the |
// |               payload word count m*n + n*p.                              |
// | Ports       : m, n, p    in  DIM_W       dimension fields                |
// |               hi_bits    in  1           a header word had bits above    |
// |                                          the dimension field             |
// |               err_code   out 2           00 ok / 01 dim / 10 capacity    |
// |               total      out 2*DIM_W+1   payload words (A + B)           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module matrix_dim_check
    import matrix_loader_pkg::*;
#(
    parameter int DIM_W  = 8,
    parameter int ADDR_W = 9
) (
    input  logic [DIM_W-1:0]   m,
    input  logic [DIM_W-1:0]   n,
    input  logic [DIM_W-1:0]   p,
    input  logic               hi_bits,
    output logic [1:0]         err_code,
    output logic [2*DIM_W:0]   total
);
    localparam int PROD_W = 2 * DIM_W;
    localparam int SUM_W  = 2 * DIM_W + 1;
    // Wide enough for header + payload and for 2^ADDR_W, so nothing truncates
    localparam int CMP_W  = (SUM_W + 1 > ADDR_W + 2) ? SUM_W + 1 : ADDR_W + 2;

    localparam logic [CMP_W-1:0] c_capacity = CMP_W'(1) << ADDR_W;

    logic [PROD_W-1:0] w_mn;
    logic [PROD_W-1:0] w_np;
    logic [CMP_W-1:0]  w_words;
    logic              w_dim_bad;

    assign w_mn    = PROD_W'(m) * PROD_W'(n);
    assign w_np    = PROD_W'(n) * PROD_W'(p);
    assign total   = SUM_W'(w_mn) + SUM_W'(w_np);
    assign w_words = CMP_W'(total) + CMP_W'(HDR_WORDS);

    assign w_dim_bad = hi_bits
                     | (m == '0) | m[0]
                     | (n == '0) | n[0]
                     | (p == '0) | p[0];

    always_comb begin
        err_code = ERR_NONE;
        if (w_dim_bad) begin
            err_code = ERR_DIM;
        end else if (w_words > c_capacity) begin
            err_code = ERR_CAP;
        end
    end
endmodule
`default_nettype wire

// File: rtl/matrix_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : matrix_loader                                              |
// | Description : Write-side front end of the block matrix multiplier.       |
// |               Takes a 3-word m/n/p header followed by A (m x n) and      |
// |               B (n x p) row-major, writes every word to RAM at a         |
// |               running address, validates the header and pulses done.     |
// | Ports       : clk       in  1   clock                                    |
// |               rst       in  1   asynchronous active-low reset            |
// |               start     in  1   single-cycle load request                |
// |               bus       slave   stream in + RAM write port               |
// |               busy      out 1   load in progress                         |
// |               done      out 1   one-cycle pulse, load complete           |
// |               err       out 1   header error, held until next start      |
// |               err_code  out 2   01 dimension / 10 capacity               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module matrix_loader
    import matrix_loader_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DIM_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    matrix_loader_if.slave        bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);
    // One extra bit so an image filling the whole RAM can count past the top
    localparam int CNT_W = ADDR_W + 1;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [DIM_W-1:0]   r_m;
    logic [DIM_W-1:0]   r_n;
    logic [DIM_W-1:0]   r_p;
    logic               r_hi;
    logic               r_err;
    logic [1:0]         r_err_code;

    logic               w_ready;
    logic               w_done;
    logic               w_busy;
    logic               w_beat;
    logic               w_hdr_state;
    logic               w_hi_word;
    logic               w_last_beat;
    logic [1:0]         w_chk_code;
    logic [2*DIM_W:0]   w_total;
    logic [CNT_W-1:0]   w_last_addr;

    matrix_dim_check #(
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W)
    ) u_dim_check (
        .m        (r_m),
        .n        (r_n),
        .p        (r_p),
        .hi_bits  (r_hi),
        .err_code (w_chk_code),
        .total    (w_total)
    );

    assign w_beat      = bus.s_valid & w_ready;
    assign w_hdr_state = (r_state == ST_HDR_M) || (r_state == ST_HDR_N) || (r_state == ST_HDR_P);
    assign w_hi_word   = |bus.s_data[DATA_W-1:DIM_W];

    // Only meaningful once the header passed the check, so total <= capacity
    assign w_last_addr = CNT_W'(w_total) + CNT_W'(HDR_WORDS - 1);
    assign w_last_beat = (r_cnt == w_last_addr);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)  w_next = ST_HDR_M;
            ST_HDR_M: if (w_beat) w_next = ST_HDR_N;
            ST_HDR_N: if (w_beat) w_next = ST_HDR_P;
            ST_HDR_P: if (w_beat) w_next = ST_CHECK;
            ST_CHECK: w_next = (w_chk_code != ERR_NONE) ? ST_ERR : ST_DATA;
            ST_DATA:  if (w_beat && w_last_beat) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            ST_ERR:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- state outputs
    always_comb begin
        w_ready = 1'b0;
        w_done  = 1'b0;
        w_busy  = 1'b1;
        case (r_state)
            ST_IDLE:  w_busy  = 1'b0;
            ST_HDR_M,
            ST_HDR_N,
            ST_HDR_P,
            ST_DATA:  w_ready = 1'b1;
            ST_DONE:  w_done  = 1'b1;
            default:  ;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_m        <= '0;
            r_n        <= '0;
            r_p        <= '0;
            r_hi       <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_cnt      <= CNT_W'(ADDR_M);
                r_hi       <= 1'b0;
                r_err      <= 1'b0;
                r_err_code <= ERR_NONE;
            end else if (w_beat) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_hdr_state) begin
                    // Header field is selected by the address it is written to
                    if (r_cnt == CNT_W'(ADDR_M)) r_m <= bus.s_data[DIM_W-1:0];
                    if (r_cnt == CNT_W'(ADDR_N)) r_n <= bus.s_data[DIM_W-1:0];
                    if (r_cnt == CNT_W'(ADDR_P)) r_p <= bus.s_data[DIM_W-1:0];
                    r_hi <= r_hi | w_hi_word;
                end
            end

            if ((r_state == ST_CHECK) && (w_chk_code != ERR_NONE)) begin
                r_err      <= 1'b1;
                r_err_code <= w_chk_code;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    // Address and data are forced to zero outside a beat so the port is quiet
    assign bus.s_ready   = w_ready;
    assign bus.ram_we    = w_beat;
    assign bus.ram_addr  = w_beat ? r_cnt[ADDR_W-1:0] : '0;
    assign bus.ram_wdata = w_beat ? bus.s_data : '0;

    assign busy     = w_busy;
    assign done     = w_done;
    assign err      = r_err;
    assign err_code = r_err_code;
endmodule
`default_nettype wire

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
- Write-side front end for the block matrix multiplier.
- Accepts a valid/ready word stream carrying a 3-word dimension header followed by matrices A (m x n) and B (n x p) in row-major order.
- Validates the dimensions, writes every word into the shared RAM, and pulses done so the control unit can be started.
- It is the producer of the RAM image that the multiplier control unit consumes.

Parameters:
- data_w, 32, stream and RAM word width
- addr_w, 9, RAM address width (capacity 2^addr_w words)
- dim_w, 8, width of each dimension field

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a load
- s_valid  in  1  stream word valid
- s_ready  out  1  loader accepts the word this cycle
- s_data  in  data_w  stream word
- ram_we  out  1  RAM write enable
- ram_addr  out  addr_w  RAM write address
- ram_wdata  out  data_w  RAM write data
- busy  out  1  high from accepted start until DONE/ERR is exited
- done  out  1  one-cycle pulse: load complete and valid
- err  out  1  dimension error; held high
- err_code  out  2  01 = zero/odd/oversized dimension field, 10 = RAM capacity exceeded

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; counter 0; m, n, p cleared; all outputs 0 including err and err_code. No write occurs in the reset cycle or in the cycle of release.
- Beat: a beat is s_valid & s_ready. On a beat, in the same cycle, combinationally: ram_we=1, ram_addr=cnt, ram_wdata=s_data.
- ram_we is 0 in every other cycle.
- s_ready is 1 only in HDR_M, HDR_N, HDR_P and DATA.
- RAM layout:
  - addr 0 = m, 1 = n, 2 = p
  - A at 3 .. 3+m*n-1
  - B immediately follows A
- States:
  - IDLE: on start -> HDR_M; cnt=0; clear err and err_code; busy=1. While not in IDLE, start is ignored.
  - HDR_M / HDR_N / HDR_P: on a beat, latch s_data[dim_w-1:0] into m / n / p, cnt++, advance. After HDR_P go to CHECK.
  - CHECK (1 cycle, s_ready=0):
    - code 01 if any dimension is 0, odd, or has nonzero s_data bits above dim_w-1 (flag captured at its beat).
    - else code 10 if 3 + m*n + n*p > 2^addr_w.
    - Any error -> ERR. Otherwise total = m*n + n*p -> DATA.
  - DATA: on each beat cnt++. The beat at cnt = 3+total-1 is the last write -> DONE.
  - DONE (1 cycle): done=1 -> IDLE, busy=0.
  - ERR (1 cycle): err=1 with err_code -> IDLE. err and err_code stay held until the next accepted start.
- Arithmetic and widths:
  - Products m*n and n*p are 2*dim_w bits.
  - The sum is 2*dim_w+1 bits, compared against 2^addr_w with no truncation.
  - cnt is addr_w+1 bits internally; ram_addr is its low addr_w bits.
- Boundary conditions:
  - Header words are written to RAM before CHECK; the RAM contents after an error are unspecified to consumers.
  - s_valid gaps stall with no write and cnt unchanged.
  - Exact capacity (sum = 2^addr_w) is legal; the last address is 2^addr_w-1.
  - Reset mid-load aborts immediately; the next start restarts at addr 0.
  - start coincident with the done cycle is ignored.

Decomposition:
- Shared package:
  - state encoding: IDLE, HDR_M, HDR_N, HDR_P, CHECK, DATA, DONE, ERR
  - ERR_DIM=2'b01, ERR_CAP=2'b10
  - HDR_WORDS=3
  - header address constants 0/1/2
- One natural sub-module, matrix_dim_check: combinational check of m, n, p and the high-bit flags, producing err_code and total word count. The FSM, counter and registers stay in matrix_loader.

Test Plan:
- m=2,n=2,p=2; start, then 11 back-to-back beats with data 0..10 -> writes addr 0..10 with wdata = addr; done high exactly 1 cycle after the beat at addr 10; busy low afterwards; err=0.
- m=4,n=6,p=2; s_valid toggled every other cycle -> 39 writes, addr 0..38 contiguous, no write on idle cycles; done after addr 38.
- Header m=3 -> after the p beat, one CHECK cycle then err=1, err_code=01; no further writes while s_valid stays high; s_ready=0; err held until the next start.
- m=16,n=16,p=16 (515 > 512) -> err_code=10.
- m=16,n=16,p=14 -> 483 writes, done.
- Header word 0x0000_0102 for m -> err_code=01.
- Reset asserted during DATA at addr 7 -> all outputs 0 that cycle. Then a new start for a 2x2x2 load -> write begins at addr 0. A second start pulse issued mid-load changes nothing.
